dm_store_arbiter: RTL

//  Schedules all writes into the data-memory byte-write port. CPU stores (addr, data, 4-bit byte

---
 rtl/dm_store_arbiter.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dm_store_arbiter.sv
// -----------------------------------------------------------------------------
// dm_store_arbiter
//
// Purpose:
//   Arbiter for the data-memory byte-write port. CPU stores are queued in a
//   DEPTH-entry FIFO. A DMA/debug master requests the port directly. A
//   round-robin arbiter loads one registered write slot, and that slot drives
//   the memory. The block also reports:
//     - whether any CPU store is still pending (drain flag), and
//     - whether a pending CPU store hits the word of the load in MEM
//       (read-after-write hazard flag).
//
// Ports:
//   clk, reset            rising-edge clock; asynchronous active-low reset
//   cpu_valid/addr/wdata/be, cpu_ready
//                         CPU store handshake. be==0 is acknowledged but dropped.
//   dma_valid/addr/wdata/be, dma_ready
//                         DMA request, held until dma_ready. dma_ready is a
//                         one-cycle pulse in the cycle the request is taken.
//   mem_addr/wdata/be, mem_ready
//                         Write slot toward memory. mem_addr is word aligned.
//                         mem_be is 0 while the slot is empty.
//   raw_addr, raw_hit     Load address in MEM and the combinational overlap flag.
//   cpu_drained           No CPU store is left in the FIFO or in the slot.
// -----------------------------------------------------------------------------
module dm_store_arbiter #(
   parameter int DEPTH = 2,
   parameter int AW    = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_valid,
   input  logic [AW-1:0] cpu_addr,
   input  logic [31:0]   cpu_wdata,
   input  logic [3:0]    cpu_be,
   output logic          cpu_ready,
   input  logic          dma_valid,
   input  logic [AW-1:0] dma_addr,
   input  logic [31:0]   dma_wdata,
   input  logic [3:0]    dma_be,
   output logic          dma_ready,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   output logic [3:0]    mem_be,
   input  logic          mem_ready,
   input  logic [AW-1:0] raw_addr,
   output logic          raw_hit,
   output logic          cpu_drained
);

   localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int            CW       = PW + 1;
   localparam int            WAW      = AW - 2;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   // Source tag carried by the slot; also the encoding of rr_last.
   localparam logic SRC_CPU = 1'b0;
   localparam logic SRC_DMA = 1'b1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   // FIFO storage holds word addresses only; the byte offset is never needed.
   logic [WAW-1:0]   fifo_addr_q [DEPTH];
   logic [WAW-1:0]   fifo_addr_d [DEPTH];
   logic [31:0]      fifo_data_q [DEPTH];
   logic [31:0]      fifo_data_d [DEPTH];
   logic [3:0]       fifo_be_q   [DEPTH];
   logic [3:0]       fifo_be_d   [DEPTH];
   logic [DEPTH-1:0] fifo_vld_q;
   logic [DEPTH-1:0] fifo_vld_d;
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q;
   logic [PW-1:0]    rd_ptr_d;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;

   state_t           state_q;
   state_t           state_d;
   logic             slot_tag_q;
   logic             slot_tag_d;
   logic [WAW-1:0]   slot_addr_q;
   logic [WAW-1:0]   slot_addr_d;
   logic [31:0]      slot_data_q;
   logic [31:0]      slot_data_d;
   logic [3:0]       slot_be_q;
   logic [3:0]       slot_be_d;
   logic             rr_last_q;
   logic             rr_last_d;

   logic             cpu_cand;
   logic             dma_cand;
   logic             can_load;
   logic             grant_dma;
   logic             load;
   logic             pop;
   logic             push;
   logic             hit;

   // Byte offsets never matter for word-granular writes or hazard detection.
   logic             unused_offsets;
   assign unused_offsets = ^{cpu_addr[1:0], dma_addr[1:0], raw_addr[1:0]};

   // --------------------------------------------------------------------------
   // Arbitration, FIFO and slot next-state
   // --------------------------------------------------------------------------
   always_comb begin
      fifo_addr_d = fifo_addr_q;
      fifo_data_d = fifo_data_q;
      fifo_be_d   = fifo_be_q;
      fifo_vld_d  = fifo_vld_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      state_d     = state_q;
      slot_tag_d  = slot_tag_q;
      slot_addr_d = slot_addr_q;
      slot_data_d = slot_data_q;
      slot_be_d   = slot_be_q;
      rr_last_d   = rr_last_q;

      // Ready looks only at the registered count: a pop in the same cycle
      // does not free room for a push while the FIFO is full.
      cpu_ready = (count_q != FULL_CNT);

      cpu_cand  = (count_q != '0);
      dma_cand  = dma_valid & (dma_be != 4'b0000);
      can_load  = (state_q == ST_IDLE) | mem_ready;

      // With both sides requesting, the side that did not win last time goes.
      if (cpu_cand && dma_cand) begin
         grant_dma = (rr_last_q == SRC_CPU);
      end else begin
         grant_dma = dma_cand;
      end

      load = can_load & (cpu_cand | dma_cand);
      pop  = load & ~grant_dma;
      push = cpu_valid & cpu_ready & (cpu_be != 4'b0000);

      // A DMA request with no enables is simply acknowledged, but only in a
      // cycle where the slot could have accepted a write. Held low in reset.
      dma_ready = reset & can_load & dma_valid &
                  ((dma_be == 4'b0000) | (load & grant_dma));

      // The pop reads the old head before any push lands. A push and a pop
      // never target the same entry because pushes stop when full.
      if (pop) begin
         fifo_vld_d[rd_ptr_q] = 1'b0;
         rd_ptr_d             = rd_ptr_q + PW'(1);
      end
      if (push) begin
         fifo_vld_d[wr_ptr_q]  = 1'b1;
         fifo_addr_d[wr_ptr_q] = cpu_addr[AW-1:2];
         fifo_data_d[wr_ptr_q] = cpu_wdata;
         fifo_be_d[wr_ptr_q]   = cpu_be;
         wr_ptr_d              = wr_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);

      // Slot FSM: a load always wins over a plain retire.
      if (load) begin
         state_d    = ST_HOLD;
         slot_tag_d = grant_dma ? SRC_DMA : SRC_CPU;
         rr_last_d  = grant_dma ? SRC_DMA : SRC_CPU;
         if (grant_dma) begin
            slot_addr_d = dma_addr[AW-1:2];
            slot_data_d = dma_wdata;
            slot_be_d   = dma_be;
         end else begin
            slot_addr_d = fifo_addr_q[rd_ptr_q];
            slot_data_d = fifo_data_q[rd_ptr_q];
            slot_be_d   = fifo_be_q[rd_ptr_q];
         end
      end else if ((state_q == ST_HOLD) && mem_ready) begin
         state_d = ST_IDLE;
      end
   end

   // --------------------------------------------------------------------------
   // Hazard and drain flags
   // --------------------------------------------------------------------------
   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (fifo_vld_q[i] && (fifo_addr_q[i] == raw_addr[AW-1:2])) begin
            hit = 1'b1;
         end
      end
      // DMA writes are not ordered against CPU loads, so they never stall one.
      if ((state_q == ST_HOLD) && (slot_tag_q == SRC_CPU) &&
          (slot_addr_q == raw_addr[AW-1:2])) begin
         hit = 1'b1;
      end
      raw_hit     = hit;
      cpu_drained = (count_q == '0) &
                    ~((state_q == ST_HOLD) && (slot_tag_q == SRC_CPU));
   end

   // Memory side is driven straight from the slot; the enables gate on state
   // so that reset clears them without waiting for a clock.
   assign mem_addr  = {slot_addr_q, 2'b00};
   assign mem_wdata = slot_data_q;
   assign mem_be    = (state_q == ST_HOLD) ? slot_be_q : 4'b0000;

   // --------------------------------------------------------------------------
   // State registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fifo_addr_q <= '{default: '0};
         fifo_data_q <= '{default: '0};
         fifo_be_q   <= '{default: '0};
         fifo_vld_q  <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         state_q     <= ST_IDLE;
         slot_tag_q  <= SRC_CPU;
         slot_addr_q <= '0;
         slot_data_q <= '0;
         slot_be_q   <= '0;
         // Start as if DMA won last, so the CPU takes the first tie.
         rr_last_q   <= SRC_DMA;
      end else begin
         fifo_addr_q <= fifo_addr_d;
         fifo_data_q <= fifo_data_d;
         fifo_be_q   <= fifo_be_d;
         fifo_vld_q  <= fifo_vld_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         state_q     <= state_d;
         slot_tag_q  <= slot_tag_d;
         slot_addr_q <= slot_addr_d;
         slot_data_q <= slot_data_d;
         slot_be_q   <= slot_be_d;
         rr_last_q   <= rr_last_d;
      end
   end

endmodule
